// File: rtl/hack_vga_ctrl.sv
// Hack screen scan-out: 640x480@60 VGA timing, port-b word fetch, LSB-first pixel serialiser.
// Define HACK_VGA_BORDER_EN to paint the area around the 512x256 window grey instead of white.
//
// state     | meaning
// ----------+-------------------------------------------
// PH_ACTIVE | visible pixels / lines
// PH_FP     | front porch
// PH_SYNC   | sync pulse (hsync / vsync driven low)
// PH_BP     | back porch
module hack_vga_ctrl #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int X_OFFSET    = 64,
  parameter int Y_OFFSET    = 112,
  parameter int SCREEN_BASE = 16384,
  parameter int S_AW        = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic [S_AW-1:0] screen_addr_b,
  output logic            screen_ren_b,
  input  logic [15:0]     screen_rdata_b,
  output logic            vga_hsync,
  output logic            vga_vsync,
  output logic [3:0]      vga_r,
  output logic [3:0]      vga_g,
  output logic [3:0]      vga_b,
  output logic            frame_start
);

  localparam int HACK_W  = 512;
  localparam int HACK_H  = 256;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FP_S     = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_S   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_BP_S     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_FP_S     = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_S   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_BP_S     = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] X_LO       = 10'(X_OFFSET);
  localparam logic [9:0] X_HI       = 10'(X_OFFSET + HACK_W - 1);
  localparam logic [9:0] FETCH_LO   = 10'(X_OFFSET - 1);
  localparam logic [9:0] FETCH_HI   = 10'(X_OFFSET + HACK_W - 17);
  localparam logic [9:0] Y_LO       = 10'(Y_OFFSET);
  localparam logic [9:0] Y_HI       = 10'(Y_OFFSET + HACK_H - 1);
  localparam logic [S_AW-1:0] BASE  = S_AW'(SCREEN_BASE);

`ifdef HACK_VGA_BORDER_EN
  localparam logic [3:0] BORDER = 4'h8;
`else
  localparam logic [3:0] BORDER = 4'hF;
`endif

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

  function automatic phase_t decode(input logic [9:0] c, input logic [9:0] fp_s,
                                    input logic [9:0] sync_s, input logic [9:0] bp_s);
    if (c < fp_s)   return PH_ACTIVE;
    if (c < sync_s) return PH_FP;
    if (c < bp_s)   return PH_SYNC;
    return PH_BP;
  endfunction

  logic [9:0] h_cnt, v_cnt, h_nx, v_nx;
  phase_t     h_state, v_state, h_state_nx, v_state_nx;

  always_comb begin
    h_nx = h_cnt + 10'd1;
    v_nx = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nx = '0;
      v_nx = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
    h_state_nx = decode(h_nx, H_FP_S, H_SYNC_S, H_BP_S);
    v_state_nx = decode(v_nx, V_FP_S, V_SYNC_S, V_BP_S);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= PH_ACTIVE;
      v_state <= PH_ACTIVE;
    end else begin
      h_cnt   <= h_nx;
      v_cnt   <= v_nx;
      h_state <= h_state_nx;
      v_state <= v_state_nx;
    end
  end

  assign frame_start = !reset && (h_cnt == '0) && (v_cnt == '0);

  // Fetch is decided one cycle early so ren/addr are registered and land exactly on h = X_OFFSET+16w-1.
  logic [8:0]      fcol_nx;
  logic [7:0]      row_nx;
  logic            fetch_nx;
  logic [S_AW-1:0] addr_nx;

  always_comb begin
    fcol_nx  = h_nx[8:0] - FETCH_LO[8:0];
    row_nx   = v_nx[7:0] - Y_LO[7:0];
    fetch_nx = (v_nx >= Y_LO) && (v_nx <= Y_HI) &&
               (h_nx >= FETCH_LO) && (h_nx <= FETCH_HI) && (fcol_nx[3:0] == 4'd0);
    addr_nx  = BASE + S_AW'({row_nx, fcol_nx[8:4]});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      screen_ren_b  <= 1'b0;
      screen_addr_b <= '0;
    end else begin
      screen_ren_b <= fetch_nx;
      if (fetch_nx) screen_addr_b <= addr_nx;
    end
  end

  // Read data arrives in the load cycle itself, so bit 0 is used directly and the rest is shifted in.
  logic [15:0] shreg;
  logic [3:0]  col_lo;
  logic        in_win, load, pix, active;
  logic [3:0]  colour;

  always_comb begin
    col_lo = h_cnt[3:0] - X_LO[3:0];
    in_win = (h_cnt >= X_LO) && (h_cnt <= X_HI) && (v_cnt >= Y_LO) && (v_cnt <= Y_HI);
    load   = in_win && (col_lo == 4'd0);
    pix    = load ? screen_rdata_b[0] : shreg[0];
    active = (h_state == PH_ACTIVE) && (v_state == PH_ACTIVE);
    colour = 4'h0;
    if (active) colour = in_win ? (pix ? 4'h0 : 4'hF) : BORDER;
  end

  logic [3:0] s1_col, rgb_q;
  logic       s1_hs, s1_vs;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      s1_col    <= '0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      rgb_q     <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      shreg     <= load ? {1'b0, screen_rdata_b[15:1]} : {1'b0, shreg[15:1]};
      s1_col    <= colour;
      s1_hs     <= (h_state != PH_SYNC);
      s1_vs     <= (v_state != PH_SYNC);
      rgb_q     <= s1_col;
      vga_hsync <= s1_hs;
      vga_vsync <= s1_vs;
    end
  end

  assign vga_r = rgb_q;
  assign vga_g = rgb_q;
  assign vga_b = rgb_q;

endmodule

// File: doc/hack_vga_ctrl.md
Name: hack_vga_ctrl

Overview:
Scan-out controller for the Hack screen RAM read port (port b).
- Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Fetches one 16-bit screen word per 16 pixels through port b and serialises it into monochrome pixels.
- Centres the 512x256 Hack display in the 640x480 frame and fills the area outside it with a border colour.
- Port b is owned exclusively by this block; the CPU keeps port a.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
X_OFFSET, 64, first Hack pixel column within the active line
Y_OFFSET, 112, first Hack row within the active frame
SCREEN_BASE, 16384, screen RAM address of Hack pixel (0,0)
S_AW, 16, screen RAM address width

Ports:
clk  input  1  pixel clock, 25 MHz
reset  input  1  synchronous, active-high
screen_addr_b  output  S_AW  screen RAM port b address
screen_ren_b  output  1  port b read strobe, high on fetch cycles only
screen_rdata_b  input  16  port b read data, valid the cycle after the address is presented
vga_hsync  output  1  horizontal sync, active low
vga_vsync  output  1  vertical sync, active low
vga_r  output  4  red
vga_g  output  4  green
vga_b  output  4  blue
frame_start  output  1  one-cycle pulse when the counters are at h=0, v=0

Behaviour:
- Counters:
  - h_cnt runs 0..799 (H total 800); wraps to 0.
  - v_cnt runs 0..524 (V total 525); increments when h_cnt wraps; wraps to 0 after 524.
  - Both counters are 10 bits wide.
- Horizontal phase FSM, derived from h_cnt; vertical phases decoded the same way from v_cnt:
  - H_ACTIVE: 0..639
  - H_FP: 640..655
  - H_SYNC: 656..751
  - H_BP: 752..799
- Hack window: h in [X_OFFSET, X_OFFSET+511] and v in [Y_OFFSET, Y_OFFSET+255]; row = v-Y_OFFSET, col = h-X_OFFSET.
- Fetch:
  - For each window row, word w (0..31) is fetched at h_cnt = X_OFFSET+16w-1.
  - At that cycle: screen_ren_b=1 and screen_addr_b = SCREEN_BASE + row*32 + w, computed modulo 2^S_AW.
  - At all other cycles screen_ren_b=0 and screen_addr_b holds its last value.
  - Exactly 32 fetches per window row, none outside the window rows, 8192 per frame.
- Serialise:
  - screen_rdata_b is loaded into a 16-bit shift register at h_cnt = X_OFFSET+16w.
  - Pixel order is LSB first: bit 0 is the leftmost pixel of the word.
  - Pixel bit 1 = black (all channels 4'h0); bit 0 = white (4'hF).
- Output latency: vga_r/g/b, vga_hsync and vga_vsync are registered and lag the counters by exactly 2 cycles, so sync and pixels stay aligned.
- Blanking: outside H_ACTIVE/V_ACTIVE, rgb = 0.
- Sync levels:
  - vga_hsync = 0 while the delayed h phase is H_SYNC, else 1.
  - vga_vsync = 0 while the delayed v_cnt is in 490..491, else 1.
- frame_start is not delayed; it pulses at counter time.
- Reset values: counters 0, shift register 0, screen_addr_b=0, screen_ren_b=0, vga_hsync=1, vga_vsync=1, rgb=0, frame_start=0.
- Reset mid-frame or mid-fetch:
  - Any in-flight read data is discarded.
  - Counters restart at (0,0) in the cycle after reset deasserts.
  - frame_start pulses in that cycle.
  - The 2-stage output pipeline flushes to reset values.
- Wrap: at h=799, v=524 both counters go to 0 simultaneously, and frame_start asserts on the following cycle (h=0, v=0).

Optional Feature:
Macro HACK_VGA_BORDER_EN.
- Defined: active pixels outside the Hack window output grey (r=g=b=4'h8).
- Undefined: they output white (4'hF), same as Hack pixel 0.
- Timing, fetch behaviour and latency are identical in both builds.

Test Plan:
- Release reset, run 2 frames -> hsync low for exactly 96 cycles every 800; vsync low for exactly 1600 cycles (2 lines) every 420000; frame_start every 420000 cycles; first hsync fall at cycle 656+2 after (0,0).
- Line v=112 -> 32 ren pulses at h=63,79,...,559; addresses 16384..16415; no ren on v=111 or v=368.
- Line v=367 -> last address 24575 (16384+255*32+31); total 8192 ren pulses per frame.
- Word (row 0, w=0) returns 16'h0001, all others 16'h0000 -> black only at counter h=64 (observed at cycle h=66), white elsewhere in the window.
- Assert reset for 1 cycle at v=200, h=300 -> outputs return to reset values; next cycle frame_start=1 with counters at (0,0); next frame timing identical to a fresh reset.
- Build with and without HACK_VGA_BORDER_EN, sample pixel (10,10) -> 4'h8/4'h8/4'h8 vs 4'hF/4'hF/4'hF; all other checks unchanged.
